// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, redirect squash,
// and a timeout-guarded freeze while data memory is busy.
module pipeline_hazard_ctrl #(
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int LOAD_STALL_CYCLES   = 1,
    parameter int MEM_TIMEOUT         = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] ID_rs1,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] ID_rs2,
    input  logic                           ID_useRs1,
    input  logic                           ID_useRs2,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] EX_rd,
    input  logic                           EX_wrReg,
    input  logic                           EX_isLoad,
    input  logic                           redirect,
    input  logic                           mem_req,
    input  logic                           mem_ready,
    output logic                           pc_wrt_en,
    output logic                           IF_wrt_en,
    output logic                           ID_wrt_en,
    output logic                           EX_wrt_en,
    output logic                           flush_if_id,
    output logic                           bubble_ex,
    output logic                           mem_timeout,
    output logic [15:0]                    stall_cycles
);

    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, FLUSH} state_t;

    localparam logic [7:0] LS_LAST = 8'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0] MT_LAST = 8'(MEM_TIMEOUT);

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       hazard, memwait;

    assign memwait = mem_req & ~mem_ready;
    assign hazard  = EX_isLoad & EX_wrReg & (EX_rd != '0) &
                     ((ID_useRs1 & (ID_rs1 == EX_rd)) | (ID_useRs2 & (ID_rs2 == EX_rd)));

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        pc_wrt_en   = 1'b1;
        IF_wrt_en   = 1'b1;
        ID_wrt_en   = 1'b1;
        EX_wrt_en   = 1'b1;
        flush_if_id = 1'b0;
        bubble_ex   = 1'b0;
        mem_timeout = 1'b0;
        case (state_reg)
            RUN, LOAD_STALL: begin
                if (memwait) begin
                    {pc_wrt_en, IF_wrt_en, ID_wrt_en, EX_wrt_en} = 4'b0000;
                    state_next = MEM_WAIT;
                    cnt_next   = 8'd1;
                end else if (redirect) begin
                    flush_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                    state_next  = FLUSH;
                    cnt_next    = 8'd0;
                end else if (state_reg == LOAD_STALL || hazard) begin
                    pc_wrt_en = 1'b0;
                    IF_wrt_en = 1'b0;
                    bubble_ex = 1'b1;
                    if (state_reg == RUN) begin
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_next = LOAD_STALL;
                            cnt_next   = 8'd1;
                        end
                    end else if (cnt_reg == LS_LAST) begin
                        state_next = RUN;
                        cnt_next   = 8'd0;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next = RUN;
                    cnt_next   = 8'd0;
                end else if (cnt_reg == MT_LAST) begin
                    // Forced exit: release the pipeline even though memory never answered.
                    mem_timeout = 1'b1;
                    state_next  = RUN;
                    cnt_next    = 8'd0;
                end else begin
                    {pc_wrt_en, IF_wrt_en, ID_wrt_en, EX_wrt_en} = 4'b0000;
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            FLUSH: begin
                flush_if_id = 1'b1;
                if (memwait) begin
                    {pc_wrt_en, IF_wrt_en, ID_wrt_en, EX_wrt_en} = 4'b0000;
                end else begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = 8'd0;
            end
        endcase
        // Reset overrides inputs so the pipeline runs freely while held in reset.
        if (reset) begin
            {pc_wrt_en, IF_wrt_en, ID_wrt_en, EX_wrt_en} = 4'b1111;
            flush_if_id = 1'b0;
            bubble_ex   = 1'b0;
            mem_timeout = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= RUN;
            cnt_reg      <= 8'd0;
            stall_cycles <= 16'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (!pc_wrt_en && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench: stimulus queues expected per-cycle outputs, a negedge monitor
// pops and compares them against the controller.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
    logic       ID_useRs1 = 0, ID_useRs2 = 0, EX_wrReg = 0, EX_isLoad = 0;
    logic       redirect = 0, mem_req = 0, mem_ready = 0;
    logic       pc_wrt_en, IF_wrt_en, ID_wrt_en, EX_wrt_en;
    logic       flush_if_id, bubble_ex, mem_timeout;
    logic [15:0] stall_cycles;

    pipeline_hazard_ctrl #(
        .REG_INDEX_BIT_WIDTH(4),
        .LOAD_STALL_CYCLES(1),
        .MEM_TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_useRs1(ID_useRs1), .ID_useRs2(ID_useRs2),
        .EX_rd(EX_rd), .EX_wrReg(EX_wrReg), .EX_isLoad(EX_isLoad),
        .redirect(redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_wrt_en(pc_wrt_en), .IF_wrt_en(IF_wrt_en), .ID_wrt_en(ID_wrt_en), .EX_wrt_en(EX_wrt_en),
        .flush_if_id(flush_if_id), .bubble_ex(bubble_ex), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        logic        fl;
        logic        bb;
        logic        to;
        logic [15:0] st;
        int          step;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          passed = 0;
    int          step = 0;
    logic [15:0] exp_stall = 16'd0;

    task automatic chk(input string name, input int s, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL step %0d %s: got %h required %h", s, name, act, req);
    endtask

    // Apply one cycle of inputs and queue the outputs expected during that cycle.
    task automatic cyc(input logic rst, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic u1, input logic u2, input logic [3:0] rd,
                       input logic wr, input logic ld, input logic rdr,
                       input logic mreq, input logic mrdy,
                       input logic [3:0] e_en, input logic e_fl, input logic e_bb, input logic e_to);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; ID_rs1 = rs1; ID_rs2 = rs2; ID_useRs1 = u1; ID_useRs2 = u2;
        EX_rd = rd; EX_wrReg = wr; EX_isLoad = ld; redirect = rdr;
        mem_req = mreq; mem_ready = mrdy;
        if (rst) exp_stall = 16'd0;
        e.en = e_en; e.fl = e_fl; e.bb = e_bb; e.to = e_to; e.st = exp_stall; e.step = step;
        exp_q.push_back(e);
        step++;
        if (!rst && !e_en[3] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    endtask

    task automatic nop(input logic [3:0] e_en, input logic e_fl, input logic e_bb);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_en, e_fl, e_bb, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("enables", e.step, {12'd0, pc_wrt_en, IF_wrt_en, ID_wrt_en, EX_wrt_en}, {12'd0, e.en});
                chk("flush_if_id", e.step, {15'd0, flush_if_id}, {15'd0, e.fl});
                chk("bubble_ex", e.step, {15'd0, bubble_ex}, {15'd0, e.bb});
                chk("mem_timeout", e.step, {15'd0, mem_timeout}, {15'd0, e.to});
                chk("stall_cycles", e.step, stall_cycles, e.st);
            end
        end
    end

    initial begin : stimulus
        // Reset held with a memory wait pending: enables must stay high.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 0, 0, 0);
        nop(4'hF, 0, 0);
        // Load r3 in EX, ID reads rs2=3: one stall cycle with bubble.
        cyc(0, 1, 3, 1, 1, 3, 1, 1, 0, 0, 0, 4'b0011, 0, 1, 0);
        nop(4'hF, 0, 0);
        // Load r0 / unused source / non-load / load without wrReg: no hazard.
        cyc(0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 4'hF, 0, 0, 0);
        cyc(0, 5, 0, 0, 1, 5, 1, 1, 0, 0, 0, 4'hF, 0, 0, 0);
        cyc(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 4'hF, 0, 0, 0);
        cyc(0, 5, 0, 1, 0, 5, 0, 1, 0, 0, 0, 4'hF, 0, 0, 0);
        // Hazard via rs1.
        cyc(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 4'b0011, 0, 1, 0);
        // Redirect pulse: two flush cycles, bubble only in the first.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'hF, 1, 1, 0);
        nop(4'hF, 1, 0);
        nop(4'hF, 0, 0);
        // Redirect beats a simultaneous hazard.
        cyc(0, 7, 0, 1, 0, 7, 1, 1, 1, 0, 0, 4'hF, 1, 1, 0);
        nop(4'hF, 1, 0);
        // Memory busy 4 cycles, then ready.
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'hF, 0, 0, 0);
        nop(4'hF, 0, 0);
        // Memory wait during FLUSH: frozen with flush held, then finish the squash.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'hF, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'hF, 1, 0, 0);
        nop(4'hF, 0, 0);
        // Hazard + redirect + memwait together: memwait wins; hold all until timeout.
        for (int i = 0; i < 15; i++) cyc(0, 3, 0, 1, 0, 3, 1, 1, 1, 1, 0, 4'b0000, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 0, 0, 1);
        nop(4'hF, 0, 0);
        // Reset asserted in the middle of a memory wait.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 0, 0, 0);
        nop(4'hF, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'hF, 0, 0, 0);
        nop(4'hF, 0, 0);
        repeat (3) @(posedge clk);
        chk("queue_drained", step, 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
